// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode, flag and arbiter FSM types.
package alu_pkg;
  localparam int ALU_OP_W = 4;
  localparam int ALU_OP_MAX = 9;
  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, SLL = 4'd4,
    SLT = 4'd5, SLTS = 4'd6, XOR = 4'd7, SRL = 4'd8, SRA = 4'd9
  } alu_op_e;
  typedef struct packed {
    logic over_flow;
    logic carry;
    logic negative;
    logic zero;
  } alu_flags_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
// Ports: req (request vector), ptr (search start), en (window open),
//        gnt (one-hot grant), gnt_idx (index of the granted bit).
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  localparam logic [IW:0] NW = (IW+1)'(N);
  logic found;
  logic [IW:0] s;
  logic [IW:0] idx;
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    s = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      // wrap by compare so non-power-of-two N never reaches ids >= N
      idx = (s >= NW) ? s - NW : s;
      if (en && !found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        gnt_idx = idx[IW-1:0];
      end
    end
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ requesters.
// Ports: req_* (packed per-requester request channel, one-hot req_ready),
//        rsp_* (valid/ready response tagged with requester id),
//        alu_* (registered ALU inputs out, ALU result and flags in).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WIDTH-1:0]      req_a,
  input  logic [NREQ*WIDTH-1:0]      req_b,
  input  logic [NREQ*ALU_OP_W-1:0]   req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  output logic [3:0]                 rsp_flags,
  output logic                       rsp_illegal,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [ALU_OP_W-1:0]        alu_cntrl,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_zero,
  input  logic                       alu_negative,
  input  logic                       alu_carry,
  input  logic                       alu_over_flow
);
  state_e state, next_state;
  logic [IDW-1:0] ptr, win, id_q;
  logic [NREQ-1:0] gnt;
  logic window, accept;
  alu_flags_t flags_in;
  // grant window: idle, or the cycle the pending response is consumed
  assign window = !rst && (state == IDLE || (state == RESP && rsp_ready));
  assign accept = |gnt;
  assign flags_in = '{over_flow: alu_over_flow, carry: alu_carry, negative: alu_negative, zero: alu_zero};
  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .en(window),
    .gnt(gnt),
    .gnt_idx(win)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = (state == EXEC) ? RESP :
                 (state == RESP && !rsp_ready) ? RESP :
                 accept ? EXEC : IDLE;
  end
  always_comb begin
    rsp_valid = (state == RESP);
    req_ready = gnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      id_q <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_cntrl <= ADD;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_flags <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      if (accept) begin
        ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        id_q <= win;
        alu_a <= req_a[win*WIDTH +: WIDTH];
        alu_b <= req_b[win*WIDTH +: WIDTH];
        alu_cntrl <= req_op[win*ALU_OP_W +: ALU_OP_W];
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags <= flags_in;
        rsp_illegal <= alu_cntrl > ALU_OP_W'(ALU_OP_MAX);
        rsp_id <= id_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench with behavioural ALU and arbiter reference model.
module tb_alu_share_arbiter;
  localparam int W = 32;
  localparam int NREQ = 4;
  typedef struct packed {logic [31:0] r; logic [3:0] f;} alu_out_t;
  typedef struct packed {logic [1:0] id; logic [31:0] r; logic [3:0] f; logic ill;} exp_t;
  logic clk = 0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*4-1:0] req_op;
  logic rsp_valid, rsp_ready, rsp_illegal;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0] rsp_flags, alu_cntrl;
  logic alu_zero, alu_negative, alu_carry, alu_over_flow;
  alu_out_t alu_out;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cyc = 0;
  int mptr = 0;
  int w;
  bit occ = 0;
  bit exp_v, hs;
  logic [NREQ-1:0] exp_r;
  always #5 clk = ~clk;
  alu_share_arbiter #(.WIDTH(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_over_flow(alu_over_flow)
  );
  function automatic alu_out_t alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    r = 0; c = 0; v = 0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; c = a >= b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a << b[4:0];
      4'd5: r = {31'b0, a < b};
      4'd6: r = {31'b0, $signed(a) < $signed(b)};
      4'd7: r = a ^ b;
      4'd8: r = a >> b[4:0];
      4'd9: r = $signed(a) >>> b[4:0];
      default: r = 0;
    endcase
    return '{r: r, f: {v, c, r[31], r == 0}};
  endfunction
  always_comb alu_out = alu_f(alu_cntrl, alu_a, alu_b);
  assign alu_result = alu_out.r;
  assign {alu_over_flow, alu_carry, alu_negative, alu_zero} = alu_out.f;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*4 +: 4] = op;
  endtask
  // reference model: expected grants and response timing, pushes expected responses
  always @(negedge clk) begin
    if (rst) begin
      chk("req_ready_in_reset", {60'b0, req_ready}, 0);
      chk("rsp_valid_in_reset", {63'b0, rsp_valid}, 0);
      occ = 0;
      mptr = 0;
      q.delete();
    end else begin
      exp_v = occ && cyc >= resp_cyc;
      chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, exp_v});
      hs = exp_v && rsp_ready;
      exp_r = 0;
      w = -1;
      if (!occ || hs)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
      if (w >= 0) exp_r[w] = 1'b1;
      chk("req_ready", {60'b0, req_ready}, {60'b0, exp_r});
      if (hs) occ = 0;
      if (w >= 0) begin
        alu_out_t o;
        o = alu_f(req_op[w*4 +: 4], req_a[w*W +: W], req_b[w*W +: W]);
        q.push_back('{id: 2'(w), r: o.r, f: o.f, ill: req_op[w*4 +: 4] > 4'd9});
        occ = 1;
        resp_cyc = cyc + 2;
        mptr = (w + 1) % NREQ;
      end
    end
    cyc++;
  end
  // monitor: compares any presented response against the queue head
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (q.size() == 0) chk("rsp_unexpected", {63'b0, rsp_valid}, 0);
      else begin
        chk("rsp {id,result,flags,illegal}", {25'b0, rsp_id, rsp_result, rsp_flags, rsp_illegal},
            {25'b0, q[0].id, q[0].r, q[0].f, q[0].ill});
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    rst = 1; req_valid = 0; req_a = 0; req_b = 0; req_op = 0; rsp_ready = 0;
    tick(3);
    chk("reset rsp_valid", {63'b0, rsp_valid}, 0);
    chk("reset rsp_id", {62'b0, rsp_id}, 0);
    chk("reset rsp_result", {32'b0, rsp_result}, 0);
    chk("reset rsp_flags", {60'b0, rsp_flags}, 0);
    chk("reset rsp_illegal", {63'b0, rsp_illegal}, 0);
    chk("reset alu_a", {32'b0, alu_a}, 0);
    chk("reset alu_b", {32'b0, alu_b}, 0);
    chk("reset alu_cntrl", {60'b0, alu_cntrl}, 0);
    rst = 0;
    set_req(2, 5, 3, 4'd1); req_valid = 4'b0100; rsp_ready = 1;
    tick(1); req_valid = 0;
    tick(1);
    chk("sub result", {32'b0, rsp_result}, 2);
    chk("sub flags", {60'b0, rsp_flags}, 4'b0100);
    tick(3);
    for (int i = 0; i < NREQ; i++) set_req(i, i, 1, 4'd0);
    req_valid = 4'hF;
    tick(12); req_valid = 0; tick(3);
    set_req(0, 10, 20, 4'd0); set_req(1, 32'hFFFF_FFFF, 1, 4'd0);
    req_valid = 4'b0011; rsp_ready = 0;
    tick(8); rsp_ready = 1;
    tick(3); req_valid = 0; tick(4);
    set_req(1, 7, 7, 4'd12); req_valid = 4'b0010;
    tick(1); req_valid = 0;
    tick(1);
    chk("illegal flag", {63'b0, rsp_illegal}, 1);
    chk("illegal result", {32'b0, rsp_result}, 0);
    tick(3);
    set_req(1, 3, 6, 4'd7); req_valid = 4'b0010;
    for (int i = 0; i < 20 && req_ready == 0; i++) @(negedge clk);
    chk("accept before reset", {60'b0, req_ready}, 4'b0010);
    @(posedge clk); #1;
    req_valid = 0; rst = 1;
    #1;
    chk("abort rsp_valid", {63'b0, rsp_valid}, 0);
    chk("abort alu_cntrl", {60'b0, alu_cntrl}, 0);
    tick(1); rst = 0;
    set_req(3, 100, 23, 4'd0); req_valid = 4'b1000;
    tick(1); req_valid = 0; tick(4);
    set_req(0, 1, 1, 4'd0); set_req(1, 2, 2, 4'd0); req_valid = 4'b0011;
    tick(6); req_valid = 0; tick(3);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 2) == 0)
          set_req(i, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                  4'($urandom_range(0, 15)));
      req_valid = 4'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      tick(1);
    end
    req_valid = 0; rsp_ready = 1;
    tick(5);
    chk("drain queue empty", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU instance between NREQ requesters, such as a main pipeline, a branch-compare unit and a CSR/debug path. The block arbitrates requests round-robin, registers the winner's operands and opcode into the ALU inputs for one execute cycle, and captures the result and flags. It then returns them to the winner over a valid/ready response channel tagged with the requester id. It sits beside the ALU instance at the top level and is the only driver of the ALU inputs.

Parameters:
WIDTH, 32, datapath width of operands and result
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of requester id

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept, at most one bit set (one-hot)
req_a  input  NREQ*WIDTH  packed operand A, slice i belongs to requester i
req_b  input  NREQ*WIDTH  packed operand B
req_op  input  NREQ*4  packed ALU opcode
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  index of the requester that owns the response
rsp_result  output  WIDTH  captured ALU result
rsp_flags  output  4  captured {over_flow, carry, negative, zero}
rsp_illegal  output  1  captured opcode was greater than 9
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_cntrl  output  4  registered opcode to ALU
alu_result  input  WIDTH  ALU result
alu_zero, alu_negative, alu_carry, alu_over_flow  input  1 each  ALU flags

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Grant window is open in IDLE, and in RESP on the cycle rsp_ready=1.
  - When the window is open and any req_valid is set, the round-robin winner w gets req_ready[w]=1 in the same cycle (combinational).
  - Acceptance is the cycle in which req_valid[w] and req_ready[w] are both 1.
- Round-robin rule: search starts at ptr and wraps modulo NREQ. On acceptance, ptr <= (w+1) mod NREQ. ptr is 0 after reset.
- On acceptance: alu_a/alu_b/alu_cntrl <= req_a/req_b/req_op slice w; id_q <= w; state -> EXEC.
- EXEC (exactly 1 cycle):
  - rsp_result <= alu_result; rsp_flags <= {alu_over_flow, alu_carry, alu_negative, alu_zero}.
  - rsp_illegal <= (alu_cntrl > 9); rsp_id <= id_q; state -> RESP.
- RESP: rsp_valid=1, and rsp_* hold stable until rsp_ready=1.
  - On that handshake, if a new acceptance occurs in the same cycle, go to EXEC; otherwise go to IDLE.
- Latency: acceptance at cycle T, rsp_valid at T+2. Sustained throughput is 1 op per 2 cycles when rsp_ready is held high.
- req_ready=0 for all requesters in EXEC, in RESP without rsp_ready, and while rst=1.
- Flags and result are forwarded unmodified; no reinterpretation of opcode semantics. Illegal opcodes are still issued; the response carries rsp_illegal=1 and whatever the ALU returns (0).
- A requester that drops req_valid before it is granted loses nothing; no state is kept per requester.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_illegal=0, alu_a=0, alu_b=0, alu_cntrl=0 (ADD), ptr=0.
- Reset asserted mid-operation aborts the in-flight op; no response is produced for it.
- NREQ not a power of two: ids >= NREQ are never granted, and pointer wrap uses a compare, not truncation.

Decomposition:
- Package alu_pkg: ALU_OP_W=4; enum alu_op_e (ADD=0, SUB=1, AND=2, OR=3, SLL=4, SLT=5, SLTS=6, XOR=7, SRL=8, SRA=9); ALU_OP_MAX=9; packed struct alu_flags_t {over_flow, carry, negative, zero}; FSM state enum.
- Sub-module rr_arbiter #(N): inputs req[N], ptr and en; outputs one-hot gnt[N] and gnt_idx. Pure combinational. The pointer register stays in the parent.

Test Plan:
- Single request: req_valid[2]=1, a=5, b=3, op=SUB, rsp_ready=1 -> req_ready[2] at T, rsp_valid at T+2 with rsp_id=2, rsp_result=2, flags carry=1, zero=0.
- All four requesters valid continuously, op=ADD, a=i, b=1 -> grants in order 0,1,2,3,0, one every 2 cycles; rsp_result=i+1 with the matching rsp_id.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, all req_ready=0. Raise rsp_ready -> the next grant occurs in the same cycle as the handshake.
- Illegal op=12, a=7, b=7 -> rsp_illegal=1, rsp_result=0.
- Reset asserted in EXEC -> next cycle rsp_valid=0, alu_cntrl=0, ptr=0. A subsequent request from requester 3 alone is granted normally.
- Pointer fairness: requesters 0 and 1 both valid, 0 just granted -> next grant goes to 1 even though 0 is still valid.
